// File: rtl/branch_sequencer.sv
// branch_sequencer: resolves one conditional branch at a time using the shared comparator.

// comparator: unsigned magnitude compare, 00 lt, 01 gt, 10 eq.
module comparator #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [1:0]       res
);
    assign res = (a < b) ? 2'b00 : (a > b) ? 2'b01 : 2'b10;
endmodule

module branch_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int PC_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_cond,
    input  logic [PC_WIDTH-1:0]   req_pc,
    input  logic [PC_WIDTH-1:0]   req_offset,
    input  logic                  opnd_valid,
    input  logic [DATA_WIDTH-1:0] opnd_a,
    input  logic [DATA_WIDTH-1:0] opnd_b,
    input  logic                  kill,
    output logic                  stall,
    output logic                  resp_valid,
    output logic                  resp_taken,
    output logic                  resp_illegal,
    output logic                  redirect_valid,
    output logic [PC_WIDTH-1:0]   redirect_pc
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_OPND = 2'd1;
    localparam logic [1:0] COMPARE   = 2'd2;
    localparam logic [1:0] RESOLVE   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [2:0]            cond_q, cond_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH-1:0]   off_q, off_d;
    logic [PC_WIDTH-1:0]   target_q, target_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [1:0]            cmp_q, cmp_d;
    logic [1:0]            cmp_res;
    logic                  accept;
    logic                  taken;
    logic                  in_resolve;

    comparator #(.WIDTH(DATA_WIDTH)) u_cmp (
        .a   (a_q),
        .b   (b_q),
        .res (cmp_res)
    );

    assign accept     = req_valid && req_ready;
    assign in_resolve = (state_q == RESOLVE);

    // Next-state and capture logic; kill aborts any in-flight branch.
    always_comb begin
        state_d  = state_q;
        cond_d   = cond_q;
        pc_d     = pc_q;
        off_d    = off_q;
        target_d = target_q;
        a_d      = a_q;
        b_d      = b_q;
        cmp_d    = cmp_q;
        if (state_q == IDLE) begin
            if (accept) begin
                cond_d  = req_cond;
                pc_d    = req_pc;
                off_d   = req_offset;
                a_d     = opnd_valid ? opnd_a : a_q;
                b_d     = opnd_valid ? opnd_b : b_q;
                state_d = opnd_valid ? COMPARE : WAIT_OPND;
            end
        end else if (kill) begin
            state_d = IDLE;
        end else if (state_q == WAIT_OPND) begin
            if (opnd_valid) begin
                a_d     = opnd_a;
                b_d     = opnd_b;
                state_d = COMPARE;
            end
        end else if (state_q == COMPARE) begin
            cmp_d    = cmp_res;
            target_d = pc_q + PC_WIDTH'(1) + off_q;
            state_d  = RESOLVE;
        end else begin
            state_d = IDLE;
        end
    end

    // Map the registered compare code onto the branch condition; code 11 and cond 111 never take.
    always_comb begin
        taken = (cond_q == 3'd0) ? (cmp_q == 2'b10) :
                (cond_q == 3'd1) ? (cmp_q == 2'b00 || cmp_q == 2'b01) :
                (cond_q == 3'd2) ? (cmp_q == 2'b00) :
                (cond_q == 3'd3) ? (cmp_q == 2'b01) :
                (cond_q == 3'd4) ? (cmp_q == 2'b00 || cmp_q == 2'b10) :
                (cond_q == 3'd5) ? (cmp_q == 2'b01 || cmp_q == 2'b10) :
                (cond_q == 3'd6);
    end

    // State and captured data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cond_q   <= '0;
            pc_q     <= '0;
            off_q    <= '0;
            target_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cmp_q    <= '0;
        end else begin
            state_q  <= state_d;
            cond_q   <= cond_d;
            pc_q     <= pc_d;
            off_q    <= off_d;
            target_q <= target_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cmp_q    <= cmp_d;
        end
    end

    assign req_ready      = (state_q == IDLE) && !kill;
    assign stall          = (state_q != IDLE) || accept;
    assign resp_valid     = in_resolve && !kill;
    assign resp_taken     = in_resolve && taken;
    assign resp_illegal   = in_resolve && !kill && (cond_q == 3'd7);
    assign redirect_valid = in_resolve && !kill && taken;
    assign redirect_pc    = target_q;
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed self-checking bench for branch_sequencer.
module tb_branch_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_cond = '0;
    logic [15:0] req_pc = '0;
    logic [15:0] req_offset = '0;
    logic        opnd_valid = 1'b0;
    logic [15:0] opnd_a = '0;
    logic [15:0] opnd_b = '0;
    logic        kill = 1'b0;
    logic        stall;
    logic        resp_valid;
    logic        resp_taken;
    logic        resp_illegal;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    int n_checks = 0;
    int n_fail = 0;

    branch_sequencer #(.DATA_WIDTH(16), .PC_WIDTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_cond       (req_cond),
        .req_pc         (req_pc),
        .req_offset     (req_offset),
        .opnd_valid     (opnd_valid),
        .opnd_a         (opnd_a),
        .opnd_b         (opnd_b),
        .kill           (kill),
        .stall          (stall),
        .resp_valid     (resp_valid),
        .resp_taken     (resp_taken),
        .resp_illegal   (resp_illegal),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full branch: accept, wait_cycles in WAIT_OPND, COMPARE, RESOLVE, back to IDLE.
    task automatic branch(input string tag, input logic [2:0] cond, input logic [15:0] pc,
                          input logic [15:0] off, input logic [15:0] a, input logic [15:0] b,
                          input int wait_cycles, input logic exp_taken, input logic [15:0] exp_pc,
                          input logic exp_illegal);
        req_valid  = 1'b1;
        req_cond   = cond;
        req_pc     = pc;
        req_offset = off;
        opnd_a     = a;
        opnd_b     = b;
        opnd_valid = (wait_cycles == 0);
        #1;
        chk({tag, ".accept_ready"}, req_ready, 1'b1);
        chk({tag, ".accept_stall"}, stall, 1'b1);
        tick();
        req_valid = 1'b0;
        for (int d = 1; d <= wait_cycles; d++) begin
            opnd_valid = (d == wait_cycles);
            #1;
            chk({tag, ".wait_stall"}, stall, 1'b1);
            chk({tag, ".wait_resp"}, resp_valid, 1'b0);
            tick();
        end
        opnd_valid = 1'b0;
        chk({tag, ".cmp_stall"}, stall, 1'b1);
        chk({tag, ".cmp_resp"}, resp_valid, 1'b0);
        tick();
        chk({tag, ".resp_valid"}, resp_valid, 1'b1);
        chk({tag, ".resp_taken"}, resp_taken, exp_taken);
        chk({tag, ".redir_valid"}, redirect_valid, exp_taken);
        chk({tag, ".redir_pc"}, redirect_pc, exp_pc);
        chk({tag, ".illegal"}, resp_illegal, exp_illegal);
        chk({tag, ".res_stall"}, stall, 1'b1);
        tick();
        chk({tag, ".idle_ready"}, req_ready, 1'b1);
        chk({tag, ".idle_stall"}, stall, 1'b0);
        chk({tag, ".idle_resp"}, resp_valid, 1'b0);
    endtask

    logic [2:0]  tbl [6];
    logic [15:0] pa [3];
    logic [15:0] pb [3];

    initial begin
        // Expected taken per cond as {gt, eq, lt}.
        tbl[0] = 3'b010; tbl[1] = 3'b101; tbl[2] = 3'b001;
        tbl[3] = 3'b100; tbl[4] = 3'b011; tbl[5] = 3'b110;
        pa[0] = 16'h0000; pb[0] = 16'hFFFF;
        pa[1] = 16'hFFFF; pb[1] = 16'hFFFF;
        pa[2] = 16'hFFFF; pb[2] = 16'h0000;

        tick();
        chk("rst.ready", req_ready, 1'b1);
        chk("rst.stall", stall, 1'b0);
        chk("rst.resp", resp_valid, 1'b0);
        chk("rst.taken", resp_taken, 1'b0);
        chk("rst.illegal", resp_illegal, 1'b0);
        chk("rst.redir", redirect_valid, 1'b0);
        chk("rst.pc", redirect_pc, 16'h0000);
        rst_n = 1'b1;
        tick();

        branch("beq_best", 3'd0, 16'h0010, 16'h0004, 16'h1234, 16'h1234, 0, 1'b1, 16'h0015, 1'b0);
        branch("blt_wait", 3'd2, 16'h0040, 16'h0002, 16'h8000, 16'h0001, 3, 1'b0, 16'h0043, 1'b0);
        branch("j_wrap", 3'd6, 16'hFFFE, 16'h0005, 16'h0001, 16'h0002, 0, 1'b1, 16'h0004, 1'b0);
        branch("bge_back", 3'd5, 16'h0020, 16'hFFF0, 16'h0077, 16'h0077, 1, 1'b1, 16'h0011, 1'b0);
        branch("reserved", 3'd7, 16'h0100, 16'h0003, 16'h0005, 16'h0005, 0, 1'b0, 16'h0104, 1'b1);

        // Kill in WAIT_OPND together with opnd_valid.
        req_valid = 1'b1; req_cond = 3'd0; req_pc = 16'h0200; req_offset = 16'h0001;
        opnd_valid = 1'b0;
        tick();
        req_valid = 1'b0; kill = 1'b1; opnd_valid = 1'b1;
        #1;
        chk("kwait.resp", resp_valid, 1'b0);
        tick();
        kill = 1'b0; opnd_valid = 1'b0;
        #1;
        chk("kwait.ready", req_ready, 1'b1);
        chk("kwait.stall", stall, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("kwait.nopulse", resp_valid, 1'b0);
        end

        // Kill in RESOLVE of a taken BNE.
        req_valid = 1'b1; req_cond = 3'd1; req_pc = 16'h0300; req_offset = 16'h0008;
        opnd_a = 16'h0001; opnd_b = 16'h0002; opnd_valid = 1'b1;
        tick();
        req_valid = 1'b0; opnd_valid = 1'b0;
        tick();
        kill = 1'b1;
        #1;
        chk("kres.resp", resp_valid, 1'b0);
        chk("kres.redir", redirect_valid, 1'b0);
        chk("kres.illegal", resp_illegal, 1'b0);
        chk("kres.ready", req_ready, 1'b0);
        tick();
        kill = 1'b0;
        #1;
        chk("kres.idle_ready", req_ready, 1'b1);
        chk("kres.idle_resp", resp_valid, 1'b0);

        // Kill together with req_valid in IDLE.
        req_valid = 1'b1; kill = 1'b1; req_cond = 3'd6; opnd_valid = 1'b1;
        #1;
        chk("kidle.ready", req_ready, 1'b0);
        chk("kidle.stall", stall, 1'b0);
        tick();
        req_valid = 1'b0; kill = 1'b0; opnd_valid = 1'b0;
        #1;
        chk("kidle.stall2", stall, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("kidle.nopulse", resp_valid, 1'b0);
        end

        // Reset during COMPARE.
        req_valid = 1'b1; req_cond = 3'd6; req_pc = 16'h0400; req_offset = 16'h0001;
        opnd_valid = 1'b1;
        tick();
        req_valid = 1'b0; opnd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstc.ready", req_ready, 1'b1);
        chk("rstc.stall", stall, 1'b0);
        chk("rstc.resp", resp_valid, 1'b0);
        chk("rstc.taken", resp_taken, 1'b0);
        chk("rstc.redir", redirect_valid, 1'b0);
        chk("rstc.pc", redirect_pc, 16'h0000);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstc.nopulse", resp_valid, 1'b0);
            chk("rstc.nostall", stall, 1'b0);
        end

        // Sweep six conditions over lt/eq/gt with extreme operands.
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < 3; k++) begin
                logic [2:0] t;
                t = tbl[c];
                branch($sformatf("sweep_c%0d_k%0d", c, k), 3'(c), 16'h0100, 16'h0000,
                       pa[k], pb[k], 0, t[k], 16'h0101, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
